// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator built from elastic register slices.
// Define IMM_GEN_TARGET_EN to add the out_target adder (pc + imm for B, J and AUIPC).
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [CNT_W-1:0] illegal_cnt
`ifdef IMM_GEN_TARGET_EN
    ,
    output logic [XLEN-1:0]  out_target
`endif
);
    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and while valid && !ready the payload is held stable.

    localparam logic [2:0] TY_NONE = 3'd0;
    localparam logic [2:0] TY_I    = 3'd1;
    localparam logic [2:0] TY_S    = 3'd2;
    localparam logic [2:0] TY_B    = 3'd3;
    localparam logic [2:0] TY_U    = 3'd4;
    localparam logic [2:0] TY_J    = 3'd5;
    localparam logic [2:0] TY_ILL  = 3'd7;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [2:0]      dec_type;
    logic [XLEN-1:0] dec_imm;
    logic            dec_tgt;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    always_comb begin
        dec_type = TY_ILL;
        dec_imm  = '0;
        dec_tgt  = 1'b0;
        case (opcode)
            7'b0010011: begin
                dec_type = TY_I;
                // Shift-immediates carry only the shamt; funct7 must not leak into imm.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec_imm = {{(XLEN-6){1'b0}}, (XLEN == 64) ? in_instr[25] : 1'b0, in_instr[24:20]};
                else
                    dec_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_type = TY_I;
                dec_imm  = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
            end
            7'b0100011: begin
                dec_type = TY_S;
                dec_imm  = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_type = TY_B;
                dec_tgt  = 1'b1;
                dec_imm  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_type = TY_U;
                dec_tgt  = (opcode == 7'b0010111);
                dec_imm  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
            end
            7'b1101111: begin
                dec_type = TY_J;
                dec_tgt  = 1'b1;
                dec_imm  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: dec_type = TY_NONE;
            default:    dec_type = TY_ILL;
        endcase
    end

    logic [STAGES-1:0] v_vec;
    logic [STAGES-1:0] rdy;

    // rdy[i]: slice i may load this cycle (empty, or its entry moves downstream).
    always_comb begin : ready_chain
        logic nxt;
        rdy = '0;
        nxt = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = ~v_vec[i] | nxt;
            nxt    = rdy[i];
        end
    end

    assign in_ready = rdy[0] & ~flush;

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        logic            up_v;
        logic [XLEN-1:0] up_pc;
        logic [XLEN-1:0] up_imm;
        logic [2:0]      up_type;
        logic            v_q;
        logic [XLEN-1:0] pc_q;
        logic [XLEN-1:0] imm_q;
        logic [2:0]      type_q;
`ifdef IMM_GEN_TARGET_EN
        logic            up_tgt;
        logic            tgt_q;
`endif

        if (g == 0) begin : g_src
            assign up_v    = in_valid;
            assign up_pc   = in_pc;
            assign up_imm  = dec_imm;
            assign up_type = dec_type;
`ifdef IMM_GEN_TARGET_EN
            assign up_tgt  = dec_tgt;
`endif
        end else begin : g_src
            assign up_v    = g_slice[g-1].v_q;
            assign up_pc   = g_slice[g-1].pc_q;
            assign up_imm  = g_slice[g-1].imm_q;
            assign up_type = g_slice[g-1].type_q;
`ifdef IMM_GEN_TARGET_EN
            assign up_tgt  = g_slice[g-1].tgt_q;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                pc_q   <= '0;
                imm_q  <= '0;
                type_q <= TY_NONE;
`ifdef IMM_GEN_TARGET_EN
                tgt_q  <= 1'b0;
`endif
            end else begin
                if (flush)
                    v_q <= 1'b0;
                else if (rdy[g])
                    v_q <= up_v;
                if (rdy[g] && up_v && !flush) begin
                    pc_q   <= up_pc;
                    imm_q  <= up_imm;
                    type_q <= up_type;
`ifdef IMM_GEN_TARGET_EN
                    tgt_q  <= up_tgt;
`endif
                end
            end
        end

        assign v_vec[g] = v_q;
    end

    assign out_valid = v_vec[STAGES-1];
    assign out_pc    = g_slice[STAGES-1].pc_q;
    assign out_imm   = g_slice[STAGES-1].imm_q;
    assign out_type  = g_slice[STAGES-1].type_q;

`ifdef IMM_GEN_TARGET_EN
    logic [XLEN-1:0] target_q;

    // The adder sits in front of the last slice so the sum is registered with its entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            target_q <= '0;
        else if (rdy[STAGES-1] && g_slice[STAGES-1].up_v && !flush)
            target_q <= g_slice[STAGES-1].up_tgt
                      ? g_slice[STAGES-1].up_pc + g_slice[STAGES-1].up_imm : '0;
    end

    assign out_target = target_q;
`endif

    logic [CNT_W-1:0] illegal_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt_q <= '0;
        else if (out_valid && out_ready && out_type == TY_ILL && illegal_cnt_q != '1)
            illegal_cnt_q <= illegal_cnt_q + 1'b1;
    end

    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random checks of imm_gen_pipe against an arithmetic reference model.
// Exercises a 32-bit/2-stage instance and a 64-bit/3-stage instance with a narrow counter.
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [2:0]  ty;
    logic [63:0] imm;
    logic [63:0] tgt;
  } ref_t;

  localparam int STG_A = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: XLEN=32, STAGES=2, CNT_W=16 ----------------
  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0] in_pc_a, in_instr_a, out_pc_a, out_imm_a;
  logic [2:0]  out_type_a;
  logic [15:0] cnt_a;
`ifdef IMM_GEN_TARGET_EN
  logic [31:0] target_a;
`endif

  imm_gen_pipe #(.XLEN(32), .STAGES(STG_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_pc(in_pc_a), .in_instr(in_instr_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pc(out_pc_a), .out_imm(out_imm_a),
    .out_type(out_type_a), .illegal_cnt(cnt_a)
`ifdef IMM_GEN_TARGET_EN
    , .out_target(target_a)
`endif
  );

  // ---------------- DUT B: XLEN=64, STAGES=3, CNT_W=3 ----------------
  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [63:0] in_pc_b, out_pc_b, out_imm_b;
  logic [31:0] in_instr_b;
  logic [2:0]  out_type_b;
  logic [2:0]  cnt_b;
`ifdef IMM_GEN_TARGET_EN
  logic [63:0] target_b;
`endif

  imm_gen_pipe #(.XLEN(64), .STAGES(3), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pc(in_pc_b), .in_instr(in_instr_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b), .out_imm(out_imm_b),
    .out_type(out_type_b), .illegal_cnt(cnt_b)
`ifdef IMM_GEN_TARGET_EN
    , .out_target(target_b)
`endif
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [98:0] exp_q[$];           // {type, imm, pc, target} for DUT A
  logic [15:0] exp_cnt_a = '0;
  logic [2:0]  exp_cnt_b = '0;
  logic        accepted = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] snap_pc, snap_imm, snap_tgt, last_imm, last_tgt;
  logic [2:0]  snap_type, last_type;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: immediates assembled from instruction fields with signed arithmetic.
  function automatic ref_t ref_model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
    ref_t r;
    int signed s;
    longint signed sx;
    longint signed v;
    logic [63:0] m;
    s  = signed'(ins);
    sx = s;
    v  = 0;
    r.ty = 3'd7;
    case (ins[6:0])
      7'h13: begin
        r.ty = 3'd1;
        if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)
          v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        else
          v = sx >>> 20;
      end
      7'h03, 7'h67, 7'h73: begin r.ty = 3'd1; v = sx >>> 20; end
      7'h23: begin r.ty = 3'd2; v = (sx >>> 25) * 32 + longint'(ins[11:7]); end
      7'h63: begin
        r.ty = 3'd3;
        v = (sx >>> 31) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
          + longint'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin r.ty = 3'd4; v = (sx >>> 12) * 4096; end
      7'h6F: begin
        r.ty = 3'd5;
        v = (sx >>> 31) * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
          + longint'(ins[30:21]) * 2;
      end
      7'h33: r.ty = 3'd0;
      default: r.ty = 3'd7;
    endcase
    m = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    r.imm = 64'(v) & m;
    if (ins[6:0] == 7'h63 || ins[6:0] == 7'h6F || ins[6:0] == 7'h17)
      r.tgt = (pc + 64'(v)) & m;
    else
      r.tgt = '0;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h00, 7'h7F};
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  // One clock of DUT A: observe at negedge, update scoreboard, advance past the edge.
  task automatic step_a();
    logic [98:0] e;
    ref_t r;
    logic exp_rdy;
    @(negedge clk);
    check("cnt_a", 64'(cnt_a), 64'(exp_cnt_a));
    exp_rdy = !flush_a && (exp_q.size() < STG_A || out_ready_a);
    check("in_ready_a", 64'(in_ready_a), 64'(exp_rdy));
    if (stall_prev) begin
      check("stall_valid", 64'(out_valid_a), 64'd1);
      check("stall_pc", 64'(out_pc_a), 64'(snap_pc));
      check("stall_imm", 64'(out_imm_a), 64'(snap_imm));
      check("stall_type", 64'(out_type_a), 64'(snap_type));
`ifdef IMM_GEN_TARGET_EN
      check("stall_tgt", 64'(target_a), 64'(snap_tgt));
`endif
    end
    if (out_valid_a && out_ready_a) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_valid_a), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_type", 64'(out_type_a), 64'(e[98:96]));
        check("out_imm", 64'(out_imm_a), 64'(e[95:64]));
        check("out_pc", 64'(out_pc_a), 64'(e[63:32]));
`ifdef IMM_GEN_TARGET_EN
        check("out_target", 64'(target_a), 64'(e[31:0]));
        last_tgt = target_a;
`endif
        if (e[98:96] == 3'd7 && exp_cnt_a != 16'hFFFF) exp_cnt_a++;
        last_imm  = out_imm_a;
        last_type = out_type_a;
      end
    end
    if (flush_a) exp_q.delete();
    accepted = 1'b0;
    if (!flush_a && in_valid_a && in_ready_a) begin
      r = ref_model(in_instr_a, {32'b0, in_pc_a}, 32);
      exp_q.push_back({r.ty, r.imm[31:0], in_pc_a, r.tgt[31:0]});
      accepted = 1'b1;
    end
    stall_prev = out_valid_a && !out_ready_a && !flush_a;
    snap_pc = out_pc_a; snap_imm = out_imm_a; snap_type = out_type_a;
`ifdef IMM_GEN_TARGET_EN
    snap_tgt = target_a;
`else
    snap_tgt = '0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] ins, input logic [31:0] pc);
    int n;
    n = 0;
    in_valid_a = 1'b1; in_instr_a = ins; in_pc_a = pc;
    accepted = 1'b0;
    while (!accepted && n < 20) begin step_a(); n++; end
    check("push_accept", 64'(accepted), 64'd1);
    in_valid_a = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    while (exp_q.size() > 0 && n < 30) begin step_a(); n++; end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    step_a();
  endtask

  // DUT B runs one instruction at a time with out_ready held high.
  task automatic run_b(input logic [31:0] ins, input logic [63:0] pc);
    ref_t r;
    int n;
    in_valid_b = 1'b1; in_instr_b = ins; in_pc_b = pc;
    @(negedge clk);
    check("b_in_ready", 64'(in_ready_b), 64'd1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    n = 0;
    while (!out_valid_b && n < 10) begin @(posedge clk); #1; n++; end
    check("b_latency", 64'(n), 64'd2);
    r = ref_model(ins, pc, 64);
    check("b_type", 64'(out_type_b), 64'(r.ty));
    check("b_imm", out_imm_b, r.imm);
    check("b_pc", out_pc_b, pc);
`ifdef IMM_GEN_TARGET_EN
    check("b_target", target_b, r.tgt);
`endif
    if (r.ty == 3'd7 && exp_cnt_b != 3'd7) exp_cnt_b++;
    @(posedge clk); #1;
    check("b_cnt", 64'(cnt_b), 64'(exp_cnt_b));
    check("b_drained", 64'(out_valid_b), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp [3];
    int n_acc;
    int idx;
    bp[0] = 32'h00500093; bp[1] = 32'h0010A023; bp[2] = 32'h123452B7;
    rst_n = 1'b0;
    flush_a = 0; in_valid_a = 0; in_pc_a = '0; in_instr_a = '0; out_ready_a = 1;
    flush_b = 0; in_valid_b = 0; in_pc_b = '0; in_instr_b = '0; out_ready_b = 1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid_a), 64'd0);
    check("rst_imm", 64'(out_imm_a), 64'd0);
    check("rst_pc", 64'(out_pc_a), 64'd0);
    check("rst_type", 64'(out_type_a), 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready_a), 64'd1);

    // jalr latency: out_valid appears on the second edge after acceptance
    push_a(32'h000003E7, 32'h40);
    check("lat_edge1_valid", 64'(out_valid_a), 64'd0);
    step_a();
    check("lat_edge2_valid", 64'(out_valid_a), 64'd1);
    check("lat_type", 64'(out_type_a), 64'd1);
    check("lat_imm", 64'(out_imm_a), 64'd0);
    drain_a();

    // Illegal opcode
    push_a(32'h80000000, 32'h44);
    drain_a();
    check("ill_type", 64'(last_type), 64'd7);
    check("ill_imm", 64'(last_imm), 64'd0);
    check("ill_cnt", 64'(cnt_a), 64'd1);

    // Shift immediates
    push_a(32'h01F09093, 32'h48);
    drain_a();
    check("slli31", 64'(last_imm), 64'h1F);
    push_a(32'h4030D093, 32'h4C);
    drain_a();
    check("srai3", 64'(last_imm), 64'h3);

`ifdef IMM_GEN_TARGET_EN
    push_a(32'hFE000EE3, 32'h100);
    drain_a();
    check("beq_imm", 64'(last_imm), 64'hFFFFFFFC);
    check("beq_tgt", 64'(last_tgt), 64'hFC);
    push_a(32'h0080006F, 32'hFFFFFFFC);
    drain_a();
    check("jal_wrap_tgt", 64'(last_tgt), 64'h4);
`endif

    // Back-pressure: only two entries fit
    out_ready_a = 1'b0;
    idx = 0; n_acc = 0;
    in_valid_a = 1'b1; in_instr_a = bp[0]; in_pc_a = 32'h200;
    for (int k = 0; k < 5; k++) begin
      step_a();
      if (accepted) begin
        n_acc++; idx++;
        in_instr_a = bp[idx]; in_pc_a = 32'h200 + 32'(idx) * 4;
      end
    end
    check("bp_accepted", 64'(n_acc), 64'd2);
    check("bp_full", 64'(in_ready_a), 64'd0);
    out_ready_a = 1'b1;
    push_a(bp[2], 32'h208);
    drain_a();

    // Flush with two entries in flight
    out_ready_a = 1'b0;
    push_a(32'h00100013, 32'h300);
    push_a(32'h80000000, 32'h304);
    flush_a = 1'b1;
    step_a();
    flush_a = 1'b0;
    check("flush_valid", 64'(out_valid_a), 64'd0);
    out_ready_a = 1'b1;
    repeat (3) step_a();
    check("flush_cnt", 64'(cnt_a), 64'd1);

    // Random traffic with back-pressure and occasional flush
    accepted = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!in_valid_a || accepted) begin
        in_valid_a = ($urandom_range(0, 3) != 0);
        in_instr_a = rand_instr();
        in_pc_a    = $urandom();
      end
      out_ready_a = ($urandom_range(0, 3) != 0);
      flush_a     = ($urandom_range(0, 40) == 0);
      step_a();
    end
    flush_a = 1'b0;
    drain_a();

    // Reset mid-stream
    out_ready_a = 1'b0;
    push_a(32'h00000013, 32'h400);
    push_a(32'h0000006F, 32'h404);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid_a), 64'd0);
    check("mid_rst_imm", 64'(out_imm_a), 64'd0);
    check("mid_rst_pc", 64'(out_pc_a), 64'd0);
    check("mid_rst_type", 64'(out_type_a), 64'd0);
    check("mid_rst_cnt", 64'(cnt_a), 64'd0);
`ifdef IMM_GEN_TARGET_EN
    check("mid_rst_tgt", 64'(target_a), 64'd0);
`endif
    exp_q.delete();
    exp_cnt_a = '0;
    stall_prev = 1'b0;
    exp_cnt_b = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(in_ready_a), 64'd1);
    out_ready_a = 1'b1;
    repeat (2) step_a();

    // DUT B: RV64 shift, saturating 3-bit counter, random instructions
    run_b(32'h03F09093, 64'h1000);
    check("b_slli63", out_imm_b, 64'h3F);
    for (int k = 0; k < 9; k++) run_b(32'h0000007F, 64'h2000 + 64'(k) * 4);
    check("b_cnt_sat", 64'(cnt_b), 64'd7);
    for (int k = 0; k < 20; k++) run_b(rand_instr(), {32'($urandom()), 32'($urandom())});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
